// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA constants, RGB444 layout and pixel helpers
package vga_pkg;

  localparam int RGB_W = 12;
  localparam int R_MSB = 11;
  localparam int R_LSB = 8;
  localparam int G_MSB = 7;
  localparam int G_LSB = 4;
  localparam int B_MSB = 3;
  localparam int B_LSB = 0;

  // 1280x1024 @ 60 Hz timing, shared with the sync counter
  localparam int DEF_W   = 1280;
  localparam int DEF_H   = 1024;
  localparam int H_FRONT = 48;
  localparam int H_SYNC  = 112;
  localparam int H_BACK  = 248;
  localparam int H_TOTAL = DEF_W + H_FRONT + H_SYNC + H_BACK;
  localparam int V_FRONT = 1;
  localparam int V_SYNC  = 3;
  localparam int V_BACK  = 38;
  localparam int V_TOTAL = DEF_H + V_FRONT + V_SYNC + V_BACK;

  // cycles after reset release during which stale memory responses are dropped
  localparam int RST_DRAIN = 32;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  function automatic rgb444_t rgb_unpack(input logic [RGB_W-1:0] word);
    rgb444_t px;
    px.r = word[R_MSB:R_LSB];
    px.g = word[G_MSB:G_LSB];
    px.b = word[B_MSB:B_LSB];
    return px;
  endfunction

endpackage

// File: rtl/vga_fb_reader_if.sv
// rtl/vga_fb_reader_if.sv - framebuffer read request/response bundle
interface vga_fb_reader_if #(
  parameter int AW = 21
);

  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid;
  logic [11:0]   mem_rsp_data;

  modport master (
    output mem_req_valid,
    input  mem_req_ready,
    output mem_req_addr,
    input  mem_rsp_valid,
    input  mem_rsp_data
  );

  modport slave (
    input  mem_req_valid,
    output mem_req_ready,
    input  mem_req_addr,
    output mem_rsp_valid,
    output mem_rsp_data
  );

endinterface

// File: rtl/vga_fb_reader_fifo_sync.sv
// rtl/vga_fb_reader_fifo_sync.sv - show-ahead synchronous FIFO with flush
module fifo_sync #(
  parameter int width = 12,
  parameter int depth = 16,
  localparam int PW = $clog2(depth),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  // a full FIFO may still accept a push in the same cycle it pops
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vga_fb_reader.sv
// rtl/vga_fb_reader.sv - raster-order framebuffer prefetch into a pixel FIFO
module vga_fb_reader
  import vga_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int H     = DEF_H,
  parameter int AW    = 21,
  parameter int DEPTH = 16
) (
  input  logic          pxclk,
  input  logic          rst_n,
  input  logic          inframe,
  input  logic          hsync,
  input  logic          vsync,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_req_addr,
  input  logic          mem_rsp_valid,
  input  logic [11:0]   mem_rsp_data,
  output logic [3:0]    red,
  output logic [3:0]    green,
  output logic [3:0]    blue,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          underflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = AW + 1;
  localparam logic [IW-1:0] NPIX       = IW'(W * H);
  localparam logic [CW:0]   DEPTH_C    = (CW + 1)'(DEPTH);
  localparam logic [5:0]    DRAIN_INIT = 6'(RST_DRAIN);

  logic [IW-1:0] issued;
  logic [CW-1:0] outstanding;
  logic [5:0]    drain;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic [11:0]   fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          accept;
  logic          rsp_live;
  logic          push;
  logic          pop;
  rgb444_t       px;

  // fifo_count + outstanding can only fall while a request waits, so a
  // combinational valid stays asserted until accepted (vsync excepted)
  assign occupancy     = {1'b0, fifo_count} + {1'b0, outstanding};
  assign mem_req_valid = (drain == '0) && !vsync && !fifo_full
                         && (issued < NPIX) && (occupancy < DEPTH_C);
  assign mem_req_addr  = issued[AW-1:0];
  assign accept        = mem_req_valid && mem_req_ready;

  // responses with nothing outstanding, or inside the post-reset window, are stale
  assign rsp_live = mem_rsp_valid && (drain == '0) && (outstanding != '0);
  assign push     = rsp_live && !vsync;
  assign pop      = inframe && !fifo_empty;
  assign px       = rgb_unpack(fifo_dout);

  always_ff @(posedge pxclk) begin
    if (!rst_n) begin
      issued      <= '0;
      outstanding <= '0;
      drain       <= DRAIN_INIT;
    end else begin
      if (drain != '0) drain <= drain - 6'd1;
      if (vsync)       issued <= '0;
      else if (accept) issued <= issued + IW'(1);
      case ({accept, rsp_live})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge pxclk) begin
    if (!rst_n) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      underflow <= 1'b0;
    end else begin
      hsync_out <= hsync;
      vsync_out <= vsync;
      if (pop) begin
        red   <= px.r;
        green <= px.g;
        blue  <= px.b;
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
      if (inframe && fifo_empty) underflow <= 1'b1;
    end
  end

  fifo_sync #(
    .width (RGB_W),
    .depth (DEPTH)
  ) u_fifo (
    .clk   (pxclk),
    .rst_n (rst_n),
    .flush (vsync),
    .push  (push),
    .din   (mem_rsp_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_vga_fb_reader.sv
// tb/tb_vga_fb_reader.sv - randomized bench for vga_fb_reader with a queue reference model
module tb_vga_fb_reader;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int HT    = 12;
  localparam int VSL   = 2;
  localparam int VT    = VSL + 1 + H;
  localparam int FRAME = VT * HT;

  typedef struct {
    int addr;
    int due;
  } req_t;

  logic       pxclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inframe = 1'b0;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic [3:0] red, green, blue;
  logic       hsync_out, vsync_out, underflow;

  vga_fb_reader_if #(.AW(AW)) mif ();

  vga_fb_reader #(.W(W), .H(H), .AW(AW), .DEPTH(DEPTH)) dut (
    .pxclk         (pxclk),
    .rst_n         (rst_n),
    .inframe       (inframe),
    .hsync         (hsync),
    .vsync         (vsync),
    .mem_req_valid (mif.mem_req_valid),
    .mem_req_ready (mif.mem_req_ready),
    .mem_req_addr  (mif.mem_req_addr),
    .mem_rsp_valid (mif.mem_rsp_valid),
    .mem_rsp_data  (mif.mem_rsp_data),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .underflow     (underflow)
  );

  initial forever #5 pxclk = ~pxclk;

  int checks = 0;
  int errors = 0;

  // memory model and stimulus state
  req_t pend[$];
  int   cyc = 0, last_due = 0, lat_min = 1, lat_max = 1, salt = 0;
  int   ready_mode = 0, bp_left = 0, spur_cnt = 0;
  int   hx = 0, vl = 0, trunc_y = -1;
  bit   freeze = 0;

  // reference model: pixels delivered but not yet displayed, in order
  int   q[$];
  bit   m_uf = 0, exp_hs = 0, exp_vs = 0, have_exp = 0;
  int   exp_rgb = 0, exp_addr = 0;

  bit   prev_valid = 0, prev_ready = 0, prev_vs = 0, prev_rst = 0;
  int   prev_addr = 0;

  bit   xy_mode = 0, xy_pend = 0, px0_pend = 0, rst_chk = 0;
  int   xy_exp = 0, first_px = -1, pre_acc = 0, pre_acc_px0 = -1;
  int   vs_rise_pend = -1, vs_first_addr = -1, rst_first_addr = -1;
  bit   vs_first_done = 1, rst_first_done = 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int mdata(input int a);
    return (a ^ salt) & 12'hFFF;
  endfunction

  task automatic step(input bit rstn_val);
    int  cur_y, gdata, due, addr;
    bit  genuine, valid, ready, acc;
    @(negedge pxclk);
    if (have_exp) begin
      check("rgb", {red, green, blue}, exp_rgb);
      check("hsync_out", hsync_out, exp_hs);
      check("vsync_out", vsync_out, exp_vs);
      check("underflow", underflow, m_uf);
      if (xy_pend) check("xy_px", {red, green, blue}, xy_exp);
      if (px0_pend) first_px = {20'd0, red, green, blue};
    end
    have_exp = 1;

    rst_n   = rstn_val;
    cur_y   = vl - VSL - 1;
    vsync   = (vl < VSL);
    inframe = (cur_y >= 0 && cur_y < H && hx < W);
    hsync   = (hx >= 9 && hx < 11);
    if (vsync && !prev_vs) vs_rise_pend = pend.size();
    if (!vsync && prev_vs) begin
      pre_acc = 0;
      vs_first_done = 0;
    end

    if (ready_mode == 0) ready = 1;
    else if (bp_left > 0) begin
      ready = 0;
      bp_left--;
    end else begin
      ready = 1;
      if (prev_valid && $urandom_range(0, 5) == 0) begin
        ready = 0;
        bp_left = 4;
      end
    end
    mif.mem_req_ready = ready;

    genuine = 0;
    gdata = 0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      genuine = 1;
      gdata = mdata(pend[0].addr);
      void'(pend.pop_front());
    end
    mif.mem_rsp_valid = genuine;
    mif.mem_rsp_data  = 12'(gdata);
    if (!genuine && spur_cnt > 0 && rst_n) begin
      mif.mem_rsp_valid = 1;
      mif.mem_rsp_data  = 12'($urandom);
      spur_cnt--;
    end

    #1;
    valid = mif.mem_req_valid;
    addr  = int'(mif.mem_req_addr);
    if (rst_chk) begin
      rst_chk = 0;
      check("rst_valid", valid, 0);
      check("rst_addr", addr, 0);
      check("rst_rgb", {red, green, blue}, 0);
      check("rst_syncs", {hsync_out, vsync_out}, 0);
      check("rst_uf", underflow, 0);
    end
    if (vsync) check("valid_in_vsync", valid, 0);
    if (prev_valid && !prev_ready && !vsync && !prev_vs && rst_n && prev_rst) begin
      check("hold_valid", valid, 1);
      check("hold_addr", addr, prev_addr);
    end
    if (px0_pend) px0_pend = 0;
    if (rst_n && inframe && cur_y == 0 && hx == 0) begin
      px0_pend = 1;
      pre_acc_px0 = pre_acc;
    end

    acc = rst_n && valid && ready;
    if (acc) begin
      check("addr", addr, exp_addr);
      check("addr_range", addr < W * H, 1);
      due = cyc + $urandom_range(lat_min, lat_max);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr, due});
      exp_addr++;
      pre_acc++;
      if (!vs_first_done) begin vs_first_addr = addr; vs_first_done = 1; end
      if (!rst_first_done) begin rst_first_addr = addr; rst_first_done = 1; end
    end

    xy_pend = 0;
    if (!rst_n) begin
      q.delete();
      pend.delete();
      last_due = 0;
      m_uf = 0;
      exp_rgb = 0;
      exp_hs = 0;
      exp_vs = 0;
      exp_addr = 0;
      rst_first_done = 0;
    end else begin
      exp_hs = hsync;
      exp_vs = vsync;
      if (inframe && q.size() == 0) m_uf = 1;
      if (inframe && q.size() > 0) exp_rgb = q.pop_front();
      else exp_rgb = 0;
      if (vsync) begin
        q.delete();
        exp_addr = 0;
      end else if (genuine) q.push_back(gdata);
      check("occupancy", q.size() + pend.size() <= DEPTH, 1);
      if (xy_mode && inframe) begin
        xy_pend = 1;
        xy_exp = (cur_y * W + hx) ^ salt;
      end
    end

    prev_valid = valid;
    prev_ready = ready;
    prev_addr  = addr;
    prev_vs    = vsync;
    prev_rst   = rst_n;

    if (!freeze) begin
      hx++;
      if (trunc_y >= 0 && cur_y == trunc_y && hx == W) begin
        vl = 0;
        hx = 0;
        trunc_y = -1;
      end else if (hx == HT) begin
        hx = 0;
        vl++;
        if (vl == VT) vl = 0;
      end
    end
    cyc++;
  endtask

  // reset while parked in vsync, long enough for the response drain window
  task automatic start_test();
    vl = 0;
    hx = 0;
    freeze = 1;
    step(0);
    step(0);
    repeat (40) step(1);
    freeze = 0;
  endtask

  initial begin
    mif.mem_req_ready = 0;
    mif.mem_rsp_valid = 0;
    mif.mem_rsp_data  = '0;

    // ideal memory, data = addr: pixel (x,y) shows y*8+x
    ready_mode = 0; lat_min = 1; lat_max = 1; salt = 0; xy_mode = 1;
    start_test();
    repeat (2 * FRAME) step(1);
    check("ideal_uf", underflow, 0);
    check("ideal_px0", first_px, 0);
    xy_mode = 0;

    // backpressure bursts with random latency
    ready_mode = 2; lat_min = 1; lat_max = 3; salt = $urandom_range(0, 4095);
    start_test();
    repeat (3 * FRAME) step(1);

    // slow memory: starved pixels go black and raise underflow
    ready_mode = 0; lat_min = 20; lat_max = 20; salt = $urandom_range(0, 4095);
    start_test();
    repeat (FRAME) step(1);
    check("slow_uf", underflow, 1);
    check("slow_px0_black", first_px, 0);
    repeat (FRAME) step(1);
    check("slow_frame2_addr0", vs_first_addr, 0);

    // vsync arrives with requests in flight
    ready_mode = 0; lat_min = 2; lat_max = 2; salt = $urandom_range(0, 4095);
    start_test();
    trunc_y = 1;
    for (int i = 0; i < 4 * FRAME && trunc_y >= 0; i++) step(1);
    check("discard_trunc_reached", trunc_y, -1);
    repeat (FRAME) step(1);
    check("discard_pending", vs_rise_pend >= 2, 1);
    check("discard_prefetch", pre_acc_px0, DEPTH);
    check("discard_px0", first_px, mdata(0));

    // mid-frame reset followed by stale responses in the drain window
    ready_mode = 0; lat_min = 1; lat_max = 1; salt = $urandom_range(0, 4095);
    start_test();
    repeat ((VSL + 2) * HT + 3) step(1);
    step(0);
    step(0);
    rst_chk = 1;
    spur_cnt = 3;
    repeat (2 * FRAME) step(1);
    check("rst_first_addr", rst_first_addr, 0);
    check("rst_prefetch", pre_acc_px0, DEPTH);
    check("rst_px0", first_px, mdata(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
